fotosinteza_sekvencer: RTL and testbench

Controller that sequences the photosynthesis FSM (Fotosinteza) through a programmed number of production cycles. It drives the unit's svjetlost, h2o_prisutan and co2_prisutan inputs in order. It watches proizvodnja_kiseonika_out and counts oxygen-producing cycles. It sits between top-level control (start/stop) and the Fotosinteza instance.

---
 rtl/fotosinteza_pkg.sv | 47 ++++
 rtl/fotosinteza_sekvencer_if.sv | 27 ++
 rtl/fotosinteza_tajmer.sv | 25 ++
 rtl/fotosinteza_sekvencer.sv | 144 ++++++++++++++
 tb/tb_fotosinteza_sekvencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fotosinteza_pkg.sv
// Shared types and default timing for the photosynthesis sequencer: state
// enum, drive-output bundle, oxygen counter type and output decode helpers.
package fotosinteza_pkg;

  localparam int T_SVJ_DEF   = 2;
  localparam int T_H2O_DEF   = 2;
  localparam int T_PROD_DEF  = 4;
  localparam int TIMEOUT_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef logic [15:0] br_kis_t;
  localparam br_kis_t BR_KIS_MAX = 16'hFFFF;

  typedef enum logic [3:0] {
    MIROVANJE,
    SVJETLO,
    VODA,
    UGLJEN,
    CEKAJ_O2,
    PROIZVODNJA,
    GASI_CO2,
    GASI_H2O,
    GASI_SVJ,
    GOTOVO,
    GRESKA
  } stanje_t;

  typedef struct packed {
    logic svj;
    logic h2o;
    logic co2;
  } pogon_t;

  function automatic pogon_t pogon(stanje_t s);
    unique case (s)
      SVJETLO, GASI_H2O:               return '{svj: 1'b1, h2o: 1'b0, co2: 1'b0};
      VODA, GASI_CO2:                  return '{svj: 1'b1, h2o: 1'b1, co2: 1'b0};
      UGLJEN, CEKAJ_O2, PROIZVODNJA:   return '{svj: 1'b1, h2o: 1'b1, co2: 1'b1};
      default:                         return '0;
    endcase
  endfunction

  function automatic logic zauzet(stanje_t s);
    return !(s inside {MIROVANJE, GOTOVO, GRESKA});
  endfunction

endpackage

// File: rtl/fotosinteza_sekvencer_if.sv
// Control/status bundle between top-level control, the sequencer and the
// Fotosinteza unit; master drives requests, slave is the sequencer.
interface fotosinteza_sekvencer_if;
  import fotosinteza_pkg::*;

  logic       i_start;
  logic       i_stop;
  logic [7:0] i_br_ciklusa;
  logic       i_kiseonik;
  logic       o_svjetlost;
  logic       o_h2o;
  logic       o_co2;
  logic       o_busy;
  logic       o_done;
  logic       o_greska;
  br_kis_t    o_br_kiseonika;

  modport master (
    output i_start, i_stop, i_br_ciklusa, i_kiseonik,
    input  o_svjetlost, o_h2o, o_co2, o_busy, o_done, o_greska, o_br_kiseonika
  );

  modport slave (
    input  i_start, i_stop, i_br_ciklusa, i_kiseonik,
    output o_svjetlost, o_h2o, o_co2, o_busy, o_done, o_greska, o_br_kiseonika
  );
endinterface

// File: rtl/fotosinteza_tajmer.sv
// Loadable down-counter; isteklo is high once the count has reached zero.
// Loading N-1 on state entry makes the owning state last exactly N cycles.
module fotosinteza_tajmer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] vrijednost,
  output logic             isteklo
);

  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments in clocked blocks so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= vrijednost;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign isteklo = (cnt == '0);

endmodule

// File: rtl/fotosinteza_sekvencer.sv
// Sequences light, water and CO2 into the Fotosinteza unit for a programmed
// number of runs. Define FOTO_WATCHDOG_EN to abort on stalled oxygen output.
module fotosinteza_sekvencer
  import fotosinteza_pkg::*;
#(
  parameter int T_SVJ   = T_SVJ_DEF,
  parameter int T_H2O   = T_H2O_DEF,
  parameter int T_PROD  = T_PROD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  fotosinteza_sekvencer_if.slave bus
);

  localparam logic [CNT_W-1:0] K_SVJ  = CNT_W'(T_SVJ - 1);
  localparam logic [CNT_W-1:0] K_H2O  = CNT_W'(T_H2O - 1);
  localparam logic [CNT_W-1:0] K_PROD = CNT_W'(T_PROD - 1);
  localparam logic [CNT_W-1:0] K_TO   = CNT_W'(TIMEOUT - 1);

  stanje_t          st, st_nxt;
  pogon_t           pogon_q;
  logic             busy_q, done_q, greska_q, prekid;
  br_kis_t          br_kis;
  logic [CNT_W-1:0] preostalo, t_val;
  logic             t_load, t_en, t_isteklo, wd_okida;
  logic             prihvat, zaustavi;

  assign prihvat  = (st == MIROVANJE || st == GRESKA) && bus.i_start && !bus.i_stop;
  assign zaustavi = bus.i_stop && (st inside {SVJETLO, VODA, UGLJEN, CEKAJ_O2, PROIZVODNJA});

  fotosinteza_tajmer #(.CNT_W(CNT_W)) u_tajmer (
    .clk(i_clk), .rst_n(i_rst_n), .load(t_load), .en(t_en),
    .vrijednost(t_val), .isteklo(t_isteklo)
  );

`ifdef FOTO_WATCHDOG_EN
  // Counts consecutive oxygen-less production cycles; any oxygen reloads it.
  logic wd_load, wd_en, wd_isteklo;
  assign wd_load  = (st_nxt == PROIZVODNJA && st != PROIZVODNJA) ||
                    (st == PROIZVODNJA && bus.i_kiseonik);
  assign wd_en    = (st == PROIZVODNJA) && !bus.i_kiseonik;
  assign wd_okida = wd_en && wd_isteklo;

  fotosinteza_tajmer #(.CNT_W(CNT_W)) u_watchdog (
    .clk(i_clk), .rst_n(i_rst_n), .load(wd_load), .en(wd_en),
    .vrijednost(K_TO), .isteklo(wd_isteklo)
  );
`else
  assign wd_okida = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    st_nxt = st;
    t_en   = 1'b0;
    t_val  = '0;
    unique case (st)
      MIROVANJE, GRESKA:
        if (prihvat) st_nxt = (bus.i_br_ciklusa == 8'd0) ? GOTOVO : SVJETLO;
      SVJETLO:
        if (zaustavi)       st_nxt = GASI_CO2;
        else if (t_isteklo) st_nxt = VODA;
        else                t_en   = 1'b1;
      VODA:
        if (zaustavi)       st_nxt = GASI_CO2;
        else if (t_isteklo) st_nxt = UGLJEN;
        else                t_en   = 1'b1;
      UGLJEN:
        st_nxt = zaustavi ? GASI_CO2 : CEKAJ_O2;
      CEKAJ_O2:
        if (zaustavi)            st_nxt = GASI_CO2;
        else if (bus.i_kiseonik) st_nxt = PROIZVODNJA;
        else if (t_isteklo)      st_nxt = GRESKA;
        else                     t_en   = 1'b1;
      PROIZVODNJA:
        if (zaustavi)       st_nxt = GASI_CO2;
        else if (wd_okida)  st_nxt = GRESKA;
        else if (t_isteklo) st_nxt = GASI_CO2;
        else                t_en   = 1'b1;
      GASI_CO2: st_nxt = GASI_H2O;
      GASI_H2O: st_nxt = GASI_SVJ;
      GASI_SVJ:
        if (prekid)                          st_nxt = MIROVANJE;
        else if (preostalo == CNT_W'(1))     st_nxt = GOTOVO;
        else                                 st_nxt = SVJETLO;
      GOTOVO:   st_nxt = MIROVANJE;
      default:  st_nxt = MIROVANJE;
    endcase

    t_load = (st_nxt != st);
    unique case (st_nxt)
      SVJETLO:     t_val = K_SVJ;
      VODA:        t_val = K_H2O;
      CEKAJ_O2:    t_val = K_TO;
      PROIZVODNJA: t_val = K_PROD;
      default:     t_val = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st        <= MIROVANJE;
      pogon_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      greska_q  <= 1'b0;
      prekid    <= 1'b0;
      br_kis    <= '0;
      preostalo <= '0;
    end else begin
      st      <= st_nxt;
      pogon_q <= pogon(st_nxt);
      busy_q  <= zauzet(st_nxt);
      done_q  <= (st_nxt == GOTOVO);
      if (prihvat) begin
        preostalo <= CNT_W'(bus.i_br_ciklusa);
        br_kis    <= '0;
        greska_q  <= 1'b0;
        prekid    <= 1'b0;
      end else begin
        if (st == PROIZVODNJA && bus.i_kiseonik && br_kis != BR_KIS_MAX)
          br_kis <= br_kis + 1'b1;
        if (zaustavi) prekid <= 1'b1;
        // An aborted run does not consume one of the programmed runs.
        if (st == GASI_SVJ) begin
          prekid <= 1'b0;
          if (!prekid) preostalo <= preostalo - 1'b1;
        end
        if (st_nxt == GRESKA) greska_q <= 1'b1;
      end
    end
  end

  assign bus.o_svjetlost    = pogon_q.svj;
  assign bus.o_h2o          = pogon_q.h2o;
  assign bus.o_co2          = pogon_q.co2;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_greska       = greska_q;
  assign bus.o_br_kiseonika = br_kis;

endmodule

// File: tb/tb_fotosinteza_sekvencer.sv
// Self-checking bench for fotosinteza_sekvencer: directed vector table,
// hand-written corner sequences and randomized runs against a schedule model.
module tb_fotosinteza_sekvencer;

  localparam int T_SVJ   = 2;
  localparam int T_H2O   = 2;
  localparam int T_PROD  = 4;
  localparam int TIMEOUT = 8;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  fotosinteza_sekvencer_if bus ();

  fotosinteza_sekvencer #(
    .T_SVJ(T_SVJ), .T_H2O(T_H2O), .T_PROD(T_PROD), .TIMEOUT(TIMEOUT), .CNT_W(8)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // {svj, h2o, co2, busy, done, greska, oxygen count}
  function automatic logic [21:0] izlaz(logic s, logic h, logic c, logic b, logic d,
                                        logic g, logic [15:0] n);
    return {s, h, c, b, d, g, n};
  endfunction

  logic [21:0] stvarno;
  assign stvarno = {bus.o_svjetlost, bus.o_h2o, bus.o_co2, bus.o_busy, bus.o_done,
                    bus.o_greska, bus.o_br_kiseonika};

  task automatic check(input string ime, input logic [21:0] exp);
    n_vec++;
    if (stvarno !== exp) begin
      n_err++;
      $display("FAIL %s: got svj/h2o/co2/busy/done/greska=%b cnt=%0d, want %b cnt=%0d",
               ime, stvarno[21:16], stvarno[15:0], exp[21:16], exp[15:0]);
    end
  endtask

  // Drive inputs for the next edge, then sample 1 time unit after it.
  task automatic korak(input logic start, input logic stop, input logic [7:0] br,
                       input logic kis);
    bus.i_start      = start;
    bus.i_stop       = stop;
    bus.i_br_ciklusa = br;
    bus.i_kiseonik   = kis;
    @(posedge i_clk);
    #1;
  endtask

  // Directed vector table
  typedef struct {
    string       ime;
    logic        start;
    logic        stop;
    logic [7:0]  br;
    logic        kis;
    logic [21:0] exp;
  } vek_t;
  vek_t tab[$];

  task automatic dodaj(input string ime, input logic start, input logic stop,
                       input logic [7:0] br, input logic kis, input logic [21:0] exp);
    tab.push_back('{ime, start, stop, br, kis, exp});
  endtask

  // Schedule model: one entry per clock edge after start, built from phase durations.
  typedef struct {
    logic        kis;
    logic        zauzet;
    logic [21:0] exp;
  } kor_t;
  kor_t        q[$];
  logic [15:0] cnt_m;

  function automatic logic rk(input bit nas);
    return nas ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic push(input logic s, input logic h, input logic c, input logic b,
                      input logic d, input logic g, input logic kis, input bit prod);
    q.push_back('{kis, b, izlaz(s, h, c, b, d, g, cnt_m)});
    if (prod && kis) cnt_m++;
  endtask

  task automatic gen(input int br, input bit nas);
    int w;
    q.delete();
    cnt_m = '0;
    for (int r = 0; r < br; r++) begin
      repeat (T_SVJ) push(1, 0, 0, 1, 0, 0, rk(nas), 0);
      repeat (T_H2O) push(1, 1, 0, 1, 0, 0, rk(nas), 0);
      push(1, 1, 1, 1, 0, 0, rk(nas), 0);
      w = nas ? int'($urandom_range(0, TIMEOUT + 1)) : 0;
      if (w >= TIMEOUT) begin
        repeat (TIMEOUT) push(1, 1, 1, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 1, rk(nas), 0);
        push(0, 0, 0, 0, 0, 1, rk(nas), 0);
        return;
      end
      repeat (w) push(1, 1, 1, 1, 0, 0, 0, 0);
      push(1, 1, 1, 1, 0, 0, 1, 0);
      repeat (T_PROD) push(1, 1, 1, 1, 0, 0, rk(nas), 1);
      push(1, 1, 0, 1, 0, 0, rk(nas), 0);
      push(1, 0, 0, 1, 0, 0, rk(nas), 0);
      push(0, 0, 0, 1, 0, 0, rk(nas), 0);
    end
    push(0, 0, 0, 0, 1, 0, rk(nas), 0);
    push(0, 0, 0, 0, 0, 0, rk(nas), 0);
  endtask

  task automatic primijeni(input int br, input bit nas, input string ime);
    gen(br, nas);
    korak(1'b1, 1'b0, 8'(br), rk(nas));
    check($sformatf("%s[0]", ime), q[0].exp);
    for (int j = 1; j < q.size(); j++) begin
      korak((q[j-1].zauzet && nas) ? rk(1) : 1'b0, 1'b0, 8'($urandom), q[j-1].kis);
      check($sformatf("%s[%0d]", ime, j), q[j].exp);
    end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_br_ciklusa = '0; bus.i_kiseonik = 1'b0;

    i_rst_n = 1'b0;
    korak(0, 0, 0, 0);
    korak(0, 0, 0, 0);
    check("reset", izlaz(0, 0, 0, 0, 0, 0, 0));
    i_rst_n = 1'b1;

    // br=1 with oxygen always present, then start+stop together, then br=0.
    dodaj("t1_svj1",   1, 0, 1, 1, izlaz(1, 0, 0, 1, 0, 0, 0));
    dodaj("t1_svj2",   0, 0, 1, 1, izlaz(1, 0, 0, 1, 0, 0, 0));
    dodaj("t1_h2o1",   0, 0, 1, 1, izlaz(1, 1, 0, 1, 0, 0, 0));
    dodaj("t1_h2o2",   0, 0, 1, 1, izlaz(1, 1, 0, 1, 0, 0, 0));
    dodaj("t1_ugljen", 0, 0, 1, 1, izlaz(1, 1, 1, 1, 0, 0, 0));
    dodaj("t1_cekaj",  0, 0, 1, 1, izlaz(1, 1, 1, 1, 0, 0, 0));
    dodaj("t1_prod1",  0, 0, 1, 1, izlaz(1, 1, 1, 1, 0, 0, 0));
    dodaj("t1_prod2",  0, 0, 1, 1, izlaz(1, 1, 1, 1, 0, 0, 1));
    dodaj("t1_prod3",  0, 0, 1, 1, izlaz(1, 1, 1, 1, 0, 0, 2));
    dodaj("t1_prod4",  0, 0, 1, 1, izlaz(1, 1, 1, 1, 0, 0, 3));
    dodaj("t1_gco2",   0, 0, 1, 1, izlaz(1, 1, 0, 1, 0, 0, 4));
    dodaj("t1_gh2o",   0, 0, 1, 1, izlaz(1, 0, 0, 1, 0, 0, 4));
    dodaj("t1_gsvj",   0, 0, 1, 1, izlaz(0, 0, 0, 1, 0, 0, 4));
    dodaj("t1_gotovo", 0, 0, 1, 1, izlaz(0, 0, 0, 0, 1, 0, 4));
    dodaj("t1_idle",   0, 0, 1, 1, izlaz(0, 0, 0, 0, 0, 0, 4));
    dodaj("ss_idle1",  1, 1, 5, 1, izlaz(0, 0, 0, 0, 0, 0, 4));
    dodaj("ss_idle2",  0, 0, 5, 1, izlaz(0, 0, 0, 0, 0, 0, 4));
    dodaj("br0_done",  1, 0, 0, 0, izlaz(0, 0, 0, 0, 1, 0, 0));
    dodaj("br0_kraj",  0, 0, 0, 0, izlaz(0, 0, 0, 0, 0, 0, 0));
    foreach (tab[i]) begin
      korak(tab[i].start, tab[i].stop, tab[i].br, tab[i].kis);
      check(tab[i].ime, tab[i].exp);
    end

    // Three identical runs, oxygen always present.
    primijeni(3, 1'b0, "br3");

    // Oxygen never arrives: error after TIMEOUT cycles in CEKAJ_O2.
    korak(1, 0, 1, 0);
    repeat (11) korak(0, 0, 1, 0);
    korak(0, 0, 1, 0);
    check("to_zadnji_cekaj", izlaz(1, 1, 1, 1, 0, 0, 0));
    korak(0, 0, 1, 0);
    check("to_greska", izlaz(0, 0, 0, 0, 0, 1, 0));
    korak(0, 0, 1, 0);
    check("to_sticky", izlaz(0, 0, 0, 0, 0, 1, 0));
    korak(1, 0, 0, 0);
    check("to_clear", izlaz(0, 0, 0, 0, 1, 0, 0));
    korak(0, 0, 0, 0);

    // Stop sampled in the second production cycle; stop held through shutdown.
    korak(1, 0, 2, 1);
    repeat (7) korak(0, 0, 2, 1);
    check("stop_prod2", izlaz(1, 1, 1, 1, 0, 0, 1));
    korak(0, 1, 2, 1);
    check("stop_gco2", izlaz(1, 1, 0, 1, 0, 0, 2));
    korak(0, 1, 2, 1);
    check("stop_gh2o", izlaz(1, 0, 0, 1, 0, 0, 2));
    korak(0, 1, 2, 1);
    check("stop_gsvj", izlaz(0, 0, 0, 1, 0, 0, 2));
    korak(0, 0, 2, 1);
    check("stop_idle", izlaz(0, 0, 0, 0, 0, 0, 2));
    korak(0, 0, 2, 1);
    check("stop_nodone", izlaz(0, 0, 0, 0, 0, 0, 2));

    // Reset in the middle of VODA.
    korak(1, 0, 1, 1);
    korak(0, 0, 1, 1);
    korak(0, 0, 1, 1);
    check("rst_voda", izlaz(1, 1, 0, 1, 0, 0, 0));
    i_rst_n = 1'b0;
    korak(0, 0, 1, 1);
    check("rst_nula", izlaz(0, 0, 0, 0, 0, 0, 0));
    i_rst_n = 1'b1;
    korak(1, 0, 0, 1);
    check("rst_br0_done", izlaz(0, 0, 0, 0, 1, 0, 0));
    korak(0, 0, 0, 1);
    check("rst_br0_kraj", izlaz(0, 0, 0, 0, 0, 0, 0));

    // Randomized runs: oxygen delay, production oxygen and busy-time starts.
    for (int s = 0; s < 25; s++)
      primijeni(int'($urandom_range(1, 3)), 1'b1, $sformatf("rnd%0d", s));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
